bank_arbiter: RTL and testbench

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_arbiter_pkg.sv | 13 +
 rtl/bank_ram.sv | 28 ++
 rtl/bank_arbiter.sv | 117 +++++++++++
 tb/tb_bank_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bank_arbiter_pkg.sv
// Shared constants and types for the two-port, four-bank arbiter.
package bank_arbiter_pkg;

    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned BANK_SEL_W = 2;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_t;

endpackage

// File: rtl/bank_ram.sv
// Single-port bank storage: synchronous write, registered read-before-write, no reset.
module bank_ram #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << WORD_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata captures the old word even when the same access writes it
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/bank_arbiter.sv
// Two-port front end over four single-port banks with round-robin conflict resolution.
module bank_arbiter
    import bank_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int unsigned WORD_W = ADDR_W - BANK_SEL_W;

    logic [BANK_SEL_W-1:0] bank0_c;
    logic [BANK_SEL_W-1:0] bank1_c;
    logic                  same_bank_c;
    port_idx_t             prio_q;
    logic [CNT_W-1:0]      conflict_q;
    logic [BANK_SEL_W-1:0] rbank0_q;
    logic [BANK_SEL_W-1:0] rbank1_q;
    logic [DATA_W-1:0]     hold0_q;
    logic [DATA_W-1:0]     hold1_q;
    logic [DATA_W-1:0]     bank_rdata [NUM_BANKS];

    // Arbitration: only a same-bank collision consults the priority pointer
    assign bank0_c     = p0_addr[ADDR_W-1 -: BANK_SEL_W];
    assign bank1_c     = p1_addr[ADDR_W-1 -: BANK_SEL_W];
    assign same_bank_c = p0_req & p1_req & (bank0_c == bank1_c);
    assign p0_gnt      = p0_req & (~same_bank_c | (prio_q == PORT0));
    assign p1_gnt      = p1_req & (~same_bank_c | (prio_q == PORT1));

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic              sel0;
        logic              sel1;
        logic              en;
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [DATA_W-1:0] wdata;

        // Grants are exclusive per bank, so at most one of sel0/sel1 is set
        always_comb begin
            sel0  = p0_gnt && (bank0_c == BANK_SEL_W'(b));
            sel1  = p1_gnt && (bank1_c == BANK_SEL_W'(b));
            en    = (sel0 | sel1) & rst_n;
            we    = sel1 ? p1_we : p0_we;
            addr  = sel1 ? p1_addr[WORD_W-1:0] : p0_addr[WORD_W-1:0];
            wdata = sel1 ? p1_wdata : p0_wdata;
        end

        bank_ram #(
            .WORD_W (WORD_W),
            .DATA_W (DATA_W)
        ) u_bank_ram (
            .clk   (clk),
            .en    (en),
            .we    (we),
            .addr  (addr),
            .wdata (wdata),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= PORT0;
            conflict_q <= '0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            rbank0_q   <= '0;
            rbank1_q   <= '0;
            hold0_q    <= '0;
            hold1_q    <= '0;
        end else begin
            if (same_bank_c) begin
                prio_q <= (prio_q == PORT0) ? PORT1 : PORT0;
                if (conflict_q != '1) begin
                    conflict_q <= conflict_q + CNT_W'(1);
                end
            end
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt & ~p0_we) begin
                rbank0_q <= bank0_c;
            end
            if (p1_gnt & ~p1_we) begin
                rbank1_q <= bank1_c;
            end
            if (p0_rvalid) begin
                hold0_q <= p0_rdata;
            end
            if (p1_rvalid) begin
                hold1_q <= p1_rdata;
            end
        end
    end

    // Read data comes straight from the bank's output flop; held copy covers idle cycles
    assign p0_rdata     = p0_rvalid ? bank_rdata[rbank0_q] : hold0_q;
    assign p1_rdata     = p1_rvalid ? bank_rdata[rbank1_q] : hold1_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_bank_arbiter.sv
// Self-checking bench for bank_arbiter: directed vector table, reset corners, random traffic vs model.
module tb_bank_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic [15:0]       conflict_cnt;

    always #5 clk = ~clk;

    bank_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .conflict_cnt(conflict_cnt)
    );

    // Reference model: flat memory, priority bit, counter, expected read results
    logic [7:0] mmem [1024];
    bit         mknown [1024];
    bit         mprio;
    int         mcnt;
    bit         erv0, erv1, erk0, erk1;
    logic [7:0] erd0, erd1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        bit         r0, w0;
        logic [9:0] a0;
        logic [7:0] d0;
        bit         r1, w1;
        logic [9:0] a1;
        logic [7:0] d1;
        bit         eg0, eg1;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_gnt(input bit r0, input bit r1, input logic [9:0] a0,
                                      input logic [9:0] a1, output bit g0, output bit g1);
        bit same;
        same = r0 && r1 && ((a0 / 256) == (a1 / 256));
        g0   = r0 && (!same || !mprio);
        g1   = r1 && (!same || mprio);
    endfunction

    task automatic model_reset();
        mprio = 0; mcnt = 0;
        erv0 = 0; erv1 = 0; erk0 = 1; erk1 = 1; erd0 = 0; erd1 = 0;
    endtask

    task automatic check_outputs();
        chk("p0_rvalid", 32'(p0_rvalid), 32'(erv0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(erv1));
        if (erk0) chk("p0_rdata", 32'(p0_rdata), 32'(erd0));
        if (erk1) chk("p1_rdata", 32'(p1_rdata), 32'(erd1));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(mcnt));
    endtask

    // One cycle: drive at posedge+1, check grants mid-cycle, advance model at the edge, check outputs
    task automatic step(input bit r0, input bit w0, input logic [9:0] a0, input logic [7:0] d0,
                        input bit r1, input bit w1, input logic [9:0] a1, input logic [7:0] d1,
                        output bit dg0, output bit dg1);
        bit g0, g1, conflict;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #4;
        model_gnt(r0, r1, a0, a1, g0, g1);
        dg0 = p0_gnt; dg1 = p1_gnt;
        chk("p0_gnt", 32'(p0_gnt), 32'(g0));
        chk("p1_gnt", 32'(p1_gnt), 32'(g1));
        @(posedge clk);
        conflict = r0 && r1 && ((a0 / 256) == (a1 / 256));
        erv0 = g0 && !w0;
        erv1 = g1 && !w1;
        if (erv0) begin erk0 = mknown[a0]; erd0 = mmem[a0]; end
        if (erv1) begin erk1 = mknown[a1]; erd1 = mmem[a1]; end
        if (g0 && w0) begin mmem[a0] = d0; mknown[a0] = 1; end
        if (g1 && w1) begin mmem[a1] = d1; mknown[a1] = 1; end
        if (conflict) begin
            mprio = !mprio;
            if (mcnt < 65535) mcnt++;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit dg0, dg1;
        bit r0, w0, r1, w1, lg0, lg1;
        logic [9:0] a0, a1;
        logic [7:0] d0, d1;

        for (int i = 0; i < 1024; i++) mknown[i] = 0;
        model_reset();

        // Reset state and arbitration while held in reset
        rst_n = 0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        #12;
        chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 0);
        chk("rst_p0_rdata", 32'(p0_rdata), 0);
        chk("rst_p1_rdata", 32'(p1_rdata), 0);
        chk("rst_cnt", 32'(conflict_cnt), 0);
        p0_req = 1; p0_addr = 10'h004; p1_req = 1; p1_addr = 10'h0F0;
        #1;
        chk("rst_conf_g0", 32'(p0_gnt), 1);
        chk("rst_conf_g1", 32'(p1_gnt), 0);
        @(negedge clk);
        p0_req = 0; p1_req = 0;
        rst_n = 1;
        @(posedge clk); #1;

        // Directed vectors: scenarios 1-4 plus data hold
        tbl.push_back('{1,1,10'h110,8'h5A, 0,0,10'h000,8'h00, 1,0});
        tbl.push_back('{1,0,10'h005,8'h00, 1,1,10'h305,8'h3C, 1,1});
        tbl.push_back('{1,1,10'h210,8'hA5, 0,0,10'h000,8'h00, 1,0});
        tbl.push_back('{0,0,10'h000,8'h00, 1,0,10'h210,8'h00, 0,1});
        for (int k = 0; k < 2; k++) begin
            tbl.push_back('{1,0,10'h101,8'h00, 1,0,10'h102,8'h00, 1,0});
            tbl.push_back('{1,0,10'h101,8'h00, 1,0,10'h102,8'h00, 0,1});
        end
        tbl.push_back('{1,1,10'h1FF,8'h11, 1,1,10'h1FF,8'h22, 1,0});
        tbl.push_back('{0,0,10'h000,8'h00, 1,1,10'h1FF,8'h22, 0,1});
        tbl.push_back('{1,0,10'h1FF,8'h00, 0,0,10'h000,8'h00, 1,0});
        tbl.push_back('{1,0,10'h110,8'h00, 1,0,10'h210,8'h00, 1,1});
        tbl.push_back('{0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 0,0});
        foreach (tbl[i]) begin
            step(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                 tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, dg0, dg1);
            chk($sformatf("tbl%0d_g0", i), 32'(dg0), 32'(tbl[i].eg0));
            chk($sformatf("tbl%0d_g1", i), 32'(dg1), 32'(tbl[i].eg1));
        end
        chk("dir_cnt", 32'(conflict_cnt), 5);
        chk("dir_hold0", 32'(p0_rdata), 32'h5A);
        chk("dir_hold1", 32'(p1_rdata), 32'hA5);

        // Randomized traffic; an ungranted request is held unchanged
        lg0 = 1; lg1 = 1; r0 = 0; r1 = 0;
        w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!r0 || lg0) begin
                r0 = ($urandom_range(0, 3) != 0);
                w0 = 1'($urandom_range(0, 1));
                a0 = 10'(($urandom_range(0, 3) << 8) | $urandom_range(0, 3));
                d0 = 8'($urandom);
            end
            if (!r1 || lg1) begin
                r1 = ($urandom_range(0, 3) != 0);
                w1 = 1'($urandom_range(0, 1));
                a1 = 10'(($urandom_range(0, 3) << 8) | $urandom_range(0, 3));
                d1 = 8'($urandom);
            end
            step(r0, w0, a0, d0, r1, w1, a1, d1, lg0, lg1);
        end
        step(0, 0, '0, '0, 0, 0, '0, '0, dg0, dg1);

        // Saturation: preload counter near the top, then three conflicts
        force dut.conflict_q = 16'hFFFE;
        #1;
        release dut.conflict_q;
        mcnt = 65534;
        for (int k = 0; k < 3; k++) step(1, 0, 10'h300, '0, 1, 0, 10'h301, '0, dg0, dg1);
        chk("sat_cnt", 32'(conflict_cnt), 32'hFFFF);

        // Reset mid-stream right after a granted read
        step(1, 0, 10'h210, '0, 0, 0, '0, '0, dg0, dg1);
        chk("pre_rst_rvalid", 32'(p0_rvalid), 1);
        #1;
        rst_n = 0;
        #1;
        chk("async_rvalid", 32'(p0_rvalid), 0);
        chk("async_rdata", 32'(p0_rdata), 0);
        chk("async_cnt", 32'(conflict_cnt), 0);
        p0_req = 1; p0_we = 0; p0_addr = 10'h210;
        p1_req = 1; p1_we = 0; p1_addr = 10'h220;
        #1;
        chk("rst2_g0", 32'(p0_gnt), 1);
        chk("rst2_g1", 32'(p1_gnt), 0);
        @(posedge clk); #1;
        chk("rst2_no_rvalid", 32'(p0_rvalid), 0);
        @(negedge clk);
        p0_req = 0; p1_req = 0;
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;
        chk("post_rst_rvalid", 32'(p0_rvalid), 0);
        step(1, 0, 10'h300, '0, 1, 0, 10'h301, '0, dg0, dg1);
        chk("post_rst_prio", 32'(dg0), 1);
        step(1, 0, 10'h210, '0, 1, 0, 10'h110, '0, dg0, dg1);
        chk("post_rst_rd0", 32'(p0_rdata), 32'hA5);
        chk("post_rst_rd1", 32'(p1_rdata), 32'h5A);
        step(0, 0, '0, '0, 0, 0, '0, '0, dg0, dg1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
